// File: rtl/mode_reporter.sv
// mode_reporter: feeds a UART transmitter with either a 3-byte mode report
// frame ('M', rate character, 'F') or single buffered payload bytes.
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   irate_control  - rate setting reported in the frame
//   iData          - payload byte, qualified by the iData_valid strobe
//   iReport        - strobe requesting a report frame
//   itx_busy       - UART transmitter busy flag
//   otx_data       - byte launched to the transmitter
//   otx_start      - registered one-cycle launch strobe
//   obusy          - FSM active or any request pending
//   odrop          - registered one-cycle strobe for a discarded byte
module mode_reporter #(
    parameter int AUTO_REPORT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] irate_control,
    input  logic [7:0] iData,
    input  logic       iData_valid,
    input  logic       iReport,
    input  logic       itx_busy,
    output logic [7:0] otx_data,
    output logic       otx_start,
    output logic       obusy,
    output logic       odrop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [1:0] idx;
    logic [1:0] next_idx;
    logic       is_rpt;
    logic       next_is_rpt;
    logic       rpt_pend;
    logic       buf_valid;
    logic [7:0] buf_data;
    logic [1:0] rate_lat;
    logic [1:0] prev_rate;

    logic       issue;
    logic       issue_m;
    logic       issue_data;
    logic [7:0] tx_byte;
    logic [7:0] rate_char;
    logic       bad_byte;
    logic       rate_chg;
    logic       req;
    logic       accept;
    logic       drop;

    always_comb begin
        rate_char = 8'h30;
        unique case (rate_lat)
            2'b00: rate_char = 8'h31;
            2'b01: rate_char = 8'h35;
            2'b10: rate_char = 8'h41;
            2'b11: rate_char = 8'h30;
            default: rate_char = 8'h30;
        endcase
    end

    // Next state plus the byte that goes out if this edge enters ISSUE.
    always_comb begin
        next_state  = state;
        next_idx    = idx;
        next_is_rpt = is_rpt;
        issue_m     = 1'b0;
        issue_data  = 1'b0;
        tx_byte     = otx_data;
        unique case (state)
            IDLE: begin
                if (!itx_busy) begin
                    if (rpt_pend) begin
                        next_state  = ISSUE;
                        next_idx    = 2'd0;
                        next_is_rpt = 1'b1;
                        issue_m     = 1'b1;
                        tx_byte     = 8'h4D;
                    end else if (buf_valid) begin
                        next_state  = ISSUE;
                        next_idx    = 2'd0;
                        next_is_rpt = 1'b0;
                        issue_data  = 1'b1;
                        tx_byte     = buf_data;
                    end
                end
            end
            ISSUE: next_state = GUARD;
            GUARD: next_state = DRAIN;
            DRAIN: begin
                if (!itx_busy) begin
                    if (is_rpt && idx != 2'd2) begin
                        next_state = ISSUE;
                        next_idx   = idx + 2'd1;
                        tx_byte    = (idx == 2'd0) ? rate_char : 8'h46;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign issue = (next_state == ISSUE);

    always_comb begin
        bad_byte = 1'b0;
        unique case (iData)
            8'h00, 8'h4D, 8'h6D, 8'h46, 8'h66: bad_byte = 1'b1;
            default: bad_byte = 1'b0;
        endcase
    end

    // A byte arriving as the buffered one launches takes the freed slot.
    assign accept   = iData_valid && !bad_byte && (!buf_valid || issue_data);
    assign drop     = iData_valid && !accept;
    assign rate_chg = (AUTO_REPORT != 0) && (irate_control != prev_rate);
    assign req      = iReport || rate_chg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 2'd0;
            is_rpt    <= 1'b0;
            rpt_pend  <= 1'b0;
            buf_valid <= 1'b0;
            buf_data  <= 8'h00;
            rate_lat  <= 2'b00;
            prev_rate <= irate_control;
            otx_data  <= 8'h00;
            otx_start <= 1'b0;
            odrop     <= 1'b0;
        end else begin
            state     <= next_state;
            idx       <= next_idx;
            is_rpt    <= next_is_rpt;
            prev_rate <= irate_control;
            otx_start <= issue;
            odrop     <= drop;
            if (issue) begin
                otx_data <= tx_byte;
            end
            if (issue_m) begin
                rate_lat <= irate_control;
            end
            // Set wins over clear so a coincident request is kept.
            if (req) begin
                rpt_pend <= 1'b1;
            end else if (issue_m) begin
                rpt_pend <= 1'b0;
            end
            if (accept) begin
                buf_valid <= 1'b1;
                buf_data  <= iData;
            end else if (issue_data) begin
                buf_valid <= 1'b0;
            end
        end
    end

    assign obusy = (state != IDLE) || rpt_pend || buf_valid;

endmodule

// File: tb/tb_mode_reporter.sv
// tb_mode_reporter: directed test of mode_reporter with hand-computed
// expectations; launched bytes are logged by a monitor and checked.
module tb_mode_reporter;

    logic       clk;
    logic       reset;
    logic [1:0] irate_control;
    logic [7:0] iData;
    logic       iData_valid;
    logic       iReport;
    logic       itx_busy;
    logic [7:0] otx_data;
    logic       otx_start;
    logic       obusy;
    logic       odrop;

    int total;
    int bad;
    int cyc;
    logic [7:0] q_byte[$];
    int         q_cyc[$];

    mode_reporter #(.AUTO_REPORT(1)) dut (
        .clk(clk),
        .reset(reset),
        .irate_control(irate_control),
        .iData(iData),
        .iData_valid(iData_valid),
        .iReport(iReport),
        .itx_busy(itx_busy),
        .otx_data(otx_data),
        .otx_start(otx_start),
        .obusy(obusy),
        .odrop(odrop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (otx_start) begin
            q_byte.push_back(otx_data);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_log();
        q_byte.delete();
        q_cyc.delete();
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2);
        chk({tag, "_n"}, q_byte.size(), 3);
        if (q_byte.size() >= 3) begin
            chk({tag, "_b0"}, q_byte[0], b0);
            chk({tag, "_b1"}, q_byte[1], b1);
            chk({tag, "_b2"}, q_byte[2], b2);
        end
    endtask

    initial begin
        logic [7:0] drops[5];
        int c0;
        total = 0;
        bad = 0;
        cyc = 0;
        drops = '{8'h00, 8'h4D, 8'h6D, 8'h46, 8'h66};
        reset = 1'b1;
        irate_control = 2'b10;
        iData = 8'h00;
        iData_valid = 1'b0;
        iReport = 1'b0;
        itx_busy = 1'b0;
        step(3);
        chk("rst_start", otx_start, 0);
        chk("rst_drop", odrop, 0);
        chk("rst_busy", obusy, 0);
        chk("rst_data", otx_data, 8'h00);
        reset = 1'b0;
        step(2);
        chk("idle_busy", obusy, 0);

        // Report frame with rate 10
        clr_log();
        c0 = cyc;
        iReport = 1'b1;
        step(1);
        iReport = 1'b0;
        step(14);
        chk_frame("rpt", 8'h4D, 8'h41, 8'h46);
        if (q_cyc.size() >= 1) chk("rpt_lat", q_cyc[0] - c0, 2);
        chk("rpt_done", obusy, 0);

        // Data byte held off by a busy transmitter
        clr_log();
        itx_busy = 1'b1;
        iData = 8'h55;
        iData_valid = 1'b1;
        step(1);
        iData_valid = 1'b0;
        step(19);
        chk("busy_none", q_byte.size(), 0);
        chk("busy_obusy", obusy, 1);
        itx_busy = 1'b0;
        c0 = cyc;
        step(8);
        chk("dat_n", q_byte.size(), 1);
        if (q_byte.size() >= 1) begin
            chk("dat_b", q_byte[0], 8'h55);
            chk("dat_lat", q_cyc[0] - c0, 1);
        end

        // Reserved bytes are dropped
        clr_log();
        iData_valid = 1'b1;
        foreach (drops[i]) begin
            iData = drops[i];
            step(1);
            chk("rsv_drop", odrop, 1);
        end
        iData_valid = 1'b0;
        step(1);
        chk("rsv_clear", odrop, 0);
        step(6);
        chk("rsv_none", q_byte.size(), 0);
        chk("rsv_obusy", obusy, 0);

        // Second byte while the buffer is full
        clr_log();
        itx_busy = 1'b1;
        iData = 8'h12;
        iData_valid = 1'b1;
        step(1);
        chk("full_first", odrop, 0);
        iData = 8'h34;
        step(1);
        chk("full_drop", odrop, 1);
        iData_valid = 1'b0;
        step(2);
        itx_busy = 1'b0;
        step(8);
        chk("full_n", q_byte.size(), 1);
        if (q_byte.size() >= 1) chk("full_b", q_byte[0], 8'h12);

        // Data and report together: frame goes first
        clr_log();
        iData = 8'h77;
        iData_valid = 1'b1;
        iReport = 1'b1;
        step(1);
        iData_valid = 1'b0;
        iReport = 1'b0;
        step(20);
        chk("mix_n", q_byte.size(), 4);
        if (q_byte.size() >= 4) begin
            chk("mix_b0", q_byte[0], 8'h4D);
            chk("mix_b1", q_byte[1], 8'h41);
            chk("mix_b2", q_byte[2], 8'h46);
            chk("mix_b3", q_byte[3], 8'h77);
        end

        // Rate toggles merge into one frame
        clr_log();
        itx_busy = 1'b1;
        irate_control = 2'b00;
        step(1);
        irate_control = 2'b01;
        step(1);
        irate_control = 2'b00;
        step(1);
        irate_control = 2'b01;
        step(3);
        itx_busy = 1'b0;
        step(20);
        chk_frame("auto", 8'h4D, 8'h35, 8'h46);

        // Reset abandons a frame after 'M'
        clr_log();
        iReport = 1'b1;
        step(1);
        iReport = 1'b0;
        step(1);
        chk("ab_m", otx_start, 1);
        reset = 1'b1;
        step(1);
        chk("ab_busy", obusy, 0);
        chk("ab_start", otx_start, 0);
        chk("ab_data", otx_data, 8'h00);
        reset = 1'b0;
        step(20);
        chk("ab_n", q_byte.size(), 1);
        if (q_byte.size() >= 1) chk("ab_b0", q_byte[0], 8'h4D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
